// File: rtl/ext_bus_stream_fifo.sv
// ext_bus_stream_fifo
//   External-bus slave that lets the CPU push 16-bit samples into a DEPTH-word
//   FIFO. The FIFO drains to an on-chip valid/ready stream consumer. A low-water
//   interrupt asks the CPU to refill the FIFO.
//
//   Optional feature macro: EXT_BUS_STREAM_IRQ_EN
//     defined   : CTRL[0] is irq_en, and irq = registered (pending & irq_en)
//     undefined : irq is tied 0, CTRL[0] reads 0, STATUS[11] still reports pending
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   address[10:0]         byte address; register select is address[2:1]
//   bus_enable, rw        access request (held until ack), 1=read 0=write
//   byte_enable[1:0]      byte lanes for writes
//   write_data[15:0]      write data
//   read_data[15:0]       registered read data, valid while acknowledge=1
//   acknowledge           one-cycle completion pulse
//   irq                   level interrupt
//   out_data/out_valid    stream head word / count>0
//   out_ready             consumer pops head when out_valid & out_ready
//
// Register map (word offset)
//   0 DATA    W push, R head (0 if empty)
//   1 STATUS  [4:0]=count, [8]=empty, [9]=full, [10]=OVF (W1C), [11]=pending
//   2 CTRL    [0]=irq_en, [1]=flush (write-only, self-clearing)
//   3 THRESH  [4:0] low-water level
module ext_bus_stream_fifo #(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] address,
  input  logic        bus_enable,
  input  logic [1:0]  byte_enable,
  input  logic        rw,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        acknowledge,
  output logic        irq,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, wr_q;
  logic [15:0]     mem [DEPTH];
  logic            ovf_q;
  logic [4:0]      thresh_q;
  logic [15:0]     read_data_q, rd_mux;
  logic            irq_en;

  // Only address[2:1] selects a register; remaining bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{address[10:3], address[0]};

  // The access is taken on the IDLE->ACK edge; everything commits there.
  logic       acc, wr_acc;
  logic [1:0] sel;
  assign acc    = (state_q == S_IDLE) && bus_enable;
  assign wr_acc = acc && !rw;
  assign sel    = address[2:1];

  logic empty, full, pending, push_req, push, pop, flush;
  logic [15:0] push_word, status;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pending   = (16'(count_q) <= 16'(thresh_q));
  assign push_req  = wr_acc && (sel == 2'd0) && (byte_enable != 2'b00);
  assign push      = push_req && !full;   // a same-cycle pop does not make room
  assign pop       = out_valid && out_ready;
  assign flush     = wr_acc && (sel == 2'd2) && byte_enable[0] && write_data[1];
  assign push_word = {byte_enable[1] ? write_data[15:8] : 8'h00,
                      byte_enable[0] ? write_data[7:0]  : 8'h00};
  assign status    = 16'(count_q) | {4'h0, pending, ovf_q, full, empty, 8'h00};

  // ---------------- bus FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus_enable) state_d = S_ACK;
      S_ACK:   state_d = S_HOLD;
      S_HOLD:  if (!bus_enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acknowledge = (state_q == S_ACK);
  end

  // ---------------- read path ----------------
  always_comb begin
    rd_mux = 16'h0000;
    case (sel)
      2'd0: rd_mux = empty ? 16'h0000 : mem[rd_q];
      2'd1: rd_mux = status;
      2'd2: rd_mux = {15'h0000, irq_en};
      2'd3: rd_mux = {11'h000, thresh_q};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                read_data_q <= 16'h0000;
    else if (acc && rw)       read_data_q <= rd_mux;
  end
  assign read_data = read_data_q;

  // ---------------- control registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q    <= 1'b0;
      thresh_q <= 5'(LOW_WATER);
    end else begin
      if (push_req && full) ovf_q <= 1'b1;
      else if (wr_acc && sel == 2'd1 && byte_enable[1] && write_data[10]) ovf_q <= 1'b0;
      if (wr_acc && sel == 2'd3 && byte_enable[0]) thresh_q <= write_data[4:0];
    end
  end

`ifdef EXT_BUS_STREAM_IRQ_EN
  logic irq_en_q, irq_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_acc && sel == 2'd2 && byte_enable[0]) irq_en_q <= write_data[0];
      irq_q <= pending && irq_en_q;
    end
  end
  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // ---------------- FIFO ----------------
  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else       count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;   // wraps mod DEPTH
        if (pop)  rd_q <= rd_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: DATA reads and out_valid are gated by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q] <= push_word;
  end

  assign out_data  = mem[rd_q];
  assign out_valid = !empty;

endmodule
